// File: rtl/rx_slicer_4_ask_pkg.sv
// Types and helpers shared by the 4-ASK receive slicer and its reference averager.
// Pure declarations, no timing.
// No flow control.
`include "defines.vh"

package rx_slicer_4_ask_pkg;

  localparam int SAMPLE_W = `SAMPLE_W;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_e;

  // Magnitude of a sample; the most negative code has no positive twin, so it saturates.
  function automatic logic [SAMPLE_W-2:0] abs_sat(input sample_t x);
    sample_t neg;
    neg = -x;
    if (x == {1'b1, {(SAMPLE_W-1){1'b0}}})
      return {(SAMPLE_W-1){1'b1}};
    else if (x[SAMPLE_W-1])
      return neg[SAMPLE_W-2:0];
    else
      return x[SAMPLE_W-2:0];
  endfunction

endpackage

// File: rtl/defines.vh
// Shared RX datapath constants: sample word width and nominal slicer reference.
// Nominal reference is 2A with A = 32768 on a 1s17 sample scale.
`ifndef RX_SLICER_DEFINES_VH
`define RX_SLICER_DEFINES_VH
`define SAMPLE_W   18
`define SYMBOL_REF 65536
`endif

// File: rtl/rx_slicer_4_ask_ref_level_averager.sv
// Averages |x| over 2^LOG2_AVG captures and emits the mean as a new slicer reference.
// ref_val and block_done update one cycle after the capture that completes a block.
// No backpressure; one magnitude is consumed per capture strobe.
`include "defines.vh"

module ref_level_averager
  import rx_slicer_4_ask_pkg::*;
#(
  parameter int LOG2_AVG = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture,
  input  logic [SAMPLE_W-2:0]       abs_x,
  output logic signed [SAMPLE_W-1:0] ref_val,
  output logic                      block_done
);

  localparam int ACC_W = SAMPLE_W + LOG2_AVG;
  localparam logic [LOG2_AVG-1:0] CNT_ONE = 1;

  logic [ACC_W-1:0]    acc;
  logic [LOG2_AVG-1:0] cnt;
  logic [ACC_W-1:0]    total;

  // Running sum including the magnitude presented this cycle.
  assign total = acc + ACC_W'(abs_x);

  // Accumulate per capture; on the last capture of a block publish the mean and restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      ref_val    <= '0;
      block_done <= 1'b0;
    end else begin
      block_done <= 1'b0;
      if (capture) begin
        if (&cnt) begin
          ref_val    <= $signed(total[LOG2_AVG +: SAMPLE_W]);
          acc        <= '0;
          cnt        <= '0;
          block_done <= 1'b1;
        end else begin
          acc <= total;
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/rx_slicer_4_ask.sv
// 4-ASK symbol slicer with decision error output and block-averaged adaptive reference.
// rx_data/rx_err/rx_valid appear one cycle after the capturing sample; ref_level two.
// No backpressure; one decision per symbol, rx_valid is a single-cycle strobe.
`include "defines.vh"

module rx_slicer_4_ask
  import rx_slicer_4_ask_pkg::*;
#(
  parameter int LOG2_AVG     = 7,
  parameter int SAMPLE_PHASE = 0,
  parameter int REF_INIT     = `SYMBOL_REF
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  input  logic                       sam_clk_en,
  input  logic                       sym_clk_en,
  input  logic signed [SAMPLE_W-1:0] rx_in,
  output logic [1:0]                 rx_data,
  output logic                       rx_valid,
  output logic signed [SAMPLE_W-1:0] rx_err,
  output logic signed [SAMPLE_W-1:0] ref_level,
  output logic                       ref_locked
);

  state_e                      state;
  logic [1:0]                  phase;
  logic [1:0]                  sample_idx;
  logic                        capture;
  logic signed [SAMPLE_W-1:0]  avg_ref;
  logic                        block_done;

  logic signed [SAMPLE_W:0]    x_w;
  logic signed [SAMPLE_W:0]    r_w;
  logic signed [SAMPLE_W:0]    half_w;
  logic signed [SAMPLE_W:0]    level_w;
  logic signed [SAMPLE_W+1:0]  diff_w;
  logic [1:0]                  slice_dat;
  logic signed [SAMPLE_W-1:0]  err_sat;

  // The symbol strobe marks index 0 regardless of where the counter had drifted.
  assign sample_idx = sym_clk_en ? 2'd0 : phase;
  assign capture    = sam_clk_en && (sample_idx == 2'(SAMPLE_PHASE));

  // Sample phase counter, resynchronised by every symbol strobe.
  always_ff @(posedge sys_clk) begin
    if (reset)
      phase <= 2'd0;
    else if (sam_clk_en)
      phase <= sym_clk_en ? 2'd1 : phase + 2'd1;
  end

  // Decision against the current reference and error to the ideal level, one bit of headroom.
  always_comb begin
    x_w     = {rx_in[SAMPLE_W-1], rx_in};
    r_w     = {ref_level[SAMPLE_W-1], ref_level};
    half_w  = r_w >>> 1;
    slice_dat = 2'b00;
    level_w = -(r_w + half_w);
    if (x_w >= r_w) begin
      slice_dat = 2'b11;
      level_w   = r_w + half_w;
    end else if (x_w >= 0) begin
      slice_dat = 2'b10;
      level_w   = half_w;
    end else if (x_w >= -r_w) begin
      slice_dat = 2'b01;
      level_w   = -half_w;
    end
    diff_w = {x_w[SAMPLE_W], x_w} - {level_w[SAMPLE_W], level_w};
    if (diff_w > $signed(20'sd131071))
      err_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (diff_w < $signed(-20'sd131072))
      err_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      err_sat = diff_w[SAMPLE_W-1:0];
  end

  // Register the decision on each capture and strobe it for one cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rx_data  <= 2'b00;
      rx_valid <= 1'b0;
      rx_err   <= '0;
    end else begin
      rx_valid <= capture;
      if (capture) begin
        rx_data <= slice_dat;
        rx_err  <= err_sat;
      end
    end
  end

  ref_level_averager #(
    .LOG2_AVG (LOG2_AVG)
  ) u_avg (
    .clk        (sys_clk),
    .reset      (reset),
    .capture    (capture),
    .abs_x      (abs_sat(rx_in)),
    .ref_val    (avg_ref),
    .block_done (block_done)
  );

  // Reference FSM: hold the initial reference until the first block, then follow every block.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= ACQUIRE;
      ref_level  <= SAMPLE_W'(REF_INIT);
      ref_locked <= 1'b0;
    end else begin
      case (state)
        ACQUIRE: begin
          if (block_done) begin
            state      <= TRACK;
            ref_level  <= avg_ref;
            ref_locked <= 1'b1;
          end
        end
        TRACK: begin
          if (block_done)
            ref_level <= avg_ref;
        end
        default: begin
          state      <= ACQUIRE;
          ref_level  <= SAMPLE_W'(REF_INIT);
          ref_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
